// File: rtl/cfs_fifo_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfs_fifo_mc_pkg
// Description : Shared constants and helpers for the multi-channel FIFO.
//               MIN_DEPTH / MIN_CHANNELS bound the legal parameter space,
//               STATS_CNT_WIDTH sizes the optional drop counter, and
//               lvl_offset() locates a channel's slice in the flat chan_lvl.
// Revision    : 1.0 - initial release
// ============================================================================
package cfs_fifo_mc_pkg;

   localparam int MIN_DEPTH       = 2;
   localparam int MIN_CHANNELS    = 2;
   localparam int STATS_CNT_WIDTH = 16;

   // Bit offset of channel 'chan' inside the flattened level bus.
   function automatic int lvl_offset(input int chan, input int cnt_width);
      return chan * (cnt_width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cfs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cfs_rr_arbiter
// Description : Round-robin arbiter with grant lock. While idle it grants
//               the first requester after the last accepted grant (with
//               wrap). 'hold' freezes the current grant for the next cycle,
//               'advance' records the grant as served and unlocks.
// Ports       : clk, reset_n       - clock, async active-low reset
//               req[N]             - request vector
//               hold, advance      - lock current grant / consume it
//               grant[N]           - one-hot grant
//               grant_idx          - binary grant index
//               grant_valid        - a grant is being presented
// Revision    : 1.0 - initial release
// ============================================================================
module cfs_rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic          hold,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   localparam logic [0:0] C_ST_IDLE   = 1'b0;
   localparam logic [0:0] C_ST_LOCKED = 1'b1;

   logic [0:0]    r_state;
   logic [IW-1:0] r_lock_idx;
   logic [IW-1:0] r_last;
   logic [IW-1:0] w_rr_idx;
   logic [IW-1:0] w_cand;
   logic          w_rr_found;

   // Search starts one past the last served channel so every requester is
   // reached within N grants.
   always_comb begin
      w_rr_idx   = '0;
      w_rr_found = 1'b0;
      w_cand     = '0;
      for (int i = 1; i <= N; i++) begin
         w_cand = IW'((int'(r_last) + i) % N);
         if (!w_rr_found && req[w_cand]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_cand;
         end
      end
   end

   assign grant_idx   = (r_state == C_ST_LOCKED) ? r_lock_idx : w_rr_idx;
   assign grant_valid = (r_state == C_ST_LOCKED) || w_rr_found;

   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = grant_valid && (grant_idx == IW'(i));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= C_ST_IDLE;
         r_lock_idx <= '0;
         r_last     <= IW'(N - 1);
      end else if (advance) begin
         r_last  <= grant_idx;
         r_state <= C_ST_IDLE;
      end else if (hold) begin
         r_lock_idx <= grant_idx;
         r_state    <= C_ST_LOCKED;
      end else begin
         r_state <= C_ST_IDLE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cfs_fifo_mc.sv
`default_nettype none
// ============================================================================
// Module      : cfs_fifo_mc
// Description : Single-clock multi-channel FIFO. NUM_CHANNELS queues share
//               one storage array; one tagged push port, one round-robin
//               arbitrated pop port, per-channel flush and status flags.
// Ports       : clk, reset_n            - clock, async active-low reset
//               push_valid/chan/data/ready - tagged push handshake
//               pop_valid/chan/data/ready  - arbitrated pop handshake
//               flush[NUM_CHANNELS]    - per-channel synchronous clear
//               chan_lvl               - flattened per-channel levels
//               chan_full/empty/afull  - per-channel flags
// Option      : CFS_FIFO_MC_STATS_EN adds stats_clr input and the 16-bit
//               saturating push_drop_cnt output (refused push cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module cfs_fifo_mc
   import cfs_fifo_mc_pkg::*;
#(
   parameter  int DATA_WIDTH   = 32,
   parameter  int FIFO_DEPTH   = 8,
   parameter  int NUM_CHANNELS = 4,
   parameter  int AFULL_LVL    = FIFO_DEPTH - 2,
   localparam int CNT_WIDTH    = $clog2(FIFO_DEPTH),
   localparam int CH_WIDTH     = $clog2(NUM_CHANNELS)
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  push_valid,
   input  logic [CH_WIDTH-1:0]                   push_chan,
   input  logic [DATA_WIDTH-1:0]                 push_data,
   output logic                                  push_ready,
   output logic                                  pop_valid,
   output logic [CH_WIDTH-1:0]                   pop_chan,
   output logic [DATA_WIDTH-1:0]                 pop_data,
   input  logic                                  pop_ready,
   input  logic [NUM_CHANNELS-1:0]               flush,
   output logic [NUM_CHANNELS*(CNT_WIDTH+1)-1:0] chan_lvl,
   output logic [NUM_CHANNELS-1:0]               chan_full,
   output logic [NUM_CHANNELS-1:0]               chan_empty,
   output logic [NUM_CHANNELS-1:0]               chan_afull
`ifdef CFS_FIFO_MC_STATS_EN
   ,
   input  logic                                  stats_clr,
   output logic [STATS_CNT_WIDTH-1:0]            push_drop_cnt
`endif
);

   localparam int AW = $clog2(NUM_CHANNELS * FIFO_DEPTH);

   if (FIFO_DEPTH < MIN_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("cfs_fifo_mc: FIFO_DEPTH must be a power of two >= 2");
   end
   if (NUM_CHANNELS < MIN_CHANNELS) begin : g_chk_chan
      $error("cfs_fifo_mc: NUM_CHANNELS must be >= 2");
   end
   if (AFULL_LVL < 1 || AFULL_LVL > FIFO_DEPTH) begin : g_chk_afull
      $error("cfs_fifo_mc: AFULL_LVL out of range");
   end

   logic [DATA_WIDTH-1:0]   r_mem    [NUM_CHANNELS*FIFO_DEPTH];
   logic [CNT_WIDTH-1:0]    r_wr_ptr [NUM_CHANNELS];
   logic [CNT_WIDTH-1:0]    r_rd_ptr [NUM_CHANNELS];
   logic [CNT_WIDTH:0]      r_lvl    [NUM_CHANNELS];

   logic [NUM_CHANNELS-1:0] w_push_acc;
   logic [NUM_CHANNELS-1:0] w_pop_acc;
   logic [NUM_CHANNELS-1:0] w_gnt_oh;
   logic [CH_WIDTH-1:0]     w_gnt_idx;
   logic                    w_gnt_valid;
   logic                    w_flush_gnt;
   logic                    w_push_fire;
   logic [AW-1:0]           w_wr_addr;
   logic [AW-1:0]           w_rd_addr;

   // Only an in-range channel can raise push_ready, so an out-of-range
   // push_chan is never accepted.
   always_comb begin
      push_ready = 1'b0;
      w_push_acc = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (push_chan == CH_WIDTH'(c)) begin
            push_ready    = !chan_full[c] && !flush[c];
            w_push_acc[c] = push_valid && !chan_full[c] && !flush[c];
         end
      end
   end

   assign w_push_fire = |w_push_acc;
   assign w_wr_addr   = AW'(int'(push_chan) * FIFO_DEPTH + int'(r_wr_ptr[push_chan]));
   assign w_rd_addr   = AW'(int'(w_gnt_idx) * FIFO_DEPTH + int'(r_rd_ptr[w_gnt_idx]));

   // A flush on the granted channel withdraws the offer: neither lock nor
   // record it as served.
   assign w_flush_gnt = |(flush & w_gnt_oh);
   assign w_pop_acc   = (pop_valid && pop_ready) ? (w_gnt_oh & ~flush) : '0;

   cfs_rr_arbiter #(
      .N (NUM_CHANNELS)
   ) u_arb (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (~chan_empty),
      .hold        (pop_valid && !pop_ready && !w_flush_gnt),
      .advance     (pop_valid && pop_ready && !w_flush_gnt),
      .grant       (w_gnt_oh),
      .grant_idx   (w_gnt_idx),
      .grant_valid (w_gnt_valid)
   );

   assign pop_valid = w_gnt_valid;
   assign pop_chan  = w_gnt_idx;
   assign pop_data  = r_mem[w_rd_addr];

   always_ff @(posedge clk) begin
      if (w_push_fire) begin
         r_mem[w_wr_addr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            r_wr_ptr[c] <= '0;
            r_rd_ptr[c] <= '0;
            r_lvl[c]    <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (flush[c]) begin
               r_wr_ptr[c] <= '0;
               r_rd_ptr[c] <= '0;
               r_lvl[c]    <= '0;
            end else begin
               if (w_push_acc[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
               if (w_pop_acc[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
               if (w_push_acc[c] && !w_pop_acc[c]) begin
                  r_lvl[c] <= r_lvl[c] + 1'b1;
               end else if (!w_push_acc[c] && w_pop_acc[c]) begin
                  r_lvl[c] <= r_lvl[c] - 1'b1;
               end
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_flags
      assign chan_lvl[lvl_offset(i, CNT_WIDTH) +: CNT_WIDTH+1] = r_lvl[i];
      assign chan_full[i]  = (r_lvl[i] == (CNT_WIDTH+1)'(FIFO_DEPTH));
      assign chan_empty[i] = (r_lvl[i] == '0);
      assign chan_afull[i] = (r_lvl[i] >= (CNT_WIDTH+1)'(AFULL_LVL));
   end

`ifdef CFS_FIFO_MC_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         push_drop_cnt <= '0;
      end else if (stats_clr) begin
         push_drop_cnt <= '0;
      end else if (push_valid && !push_ready && (push_drop_cnt != '1)) begin
         push_drop_cnt <= push_drop_cnt + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/cfs_fifo_mc.md
Name: cfs_fifo_mc

Overview:
- Single-clock, multi-channel FIFO and the parametrised successor of the team's synchronisation FIFO.
- Holds NUM_CHANNELS independent queues in one storage array.
- Push side: one valid/ready port, tagged with a channel id.
- Pop side: one valid/ready port; a round-robin arbiter picks among non-empty channels.
- Per-channel flush, level, full, empty and almost-full flags.
- Sits between the aligner core and the APB-side logic wherever several streams share one buffer.

Parameters:
- DATA_WIDTH, 32, payload width (>=1).
- FIFO_DEPTH, 8, entries per channel (>=2, power of two).
- NUM_CHANNELS, 4, number of queues (>=2).
- AFULL_LVL, FIFO_DEPTH-2, per-channel level at or above which chan_afull asserts (1..FIFO_DEPTH).
- Localparam CNT_WIDTH = $clog2(FIFO_DEPTH).
- Localparam CH_WIDTH = $clog2(NUM_CHANNELS).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- push_valid  in  1  push request.
- push_chan  in  CH_WIDTH  target channel of the push.
- push_data  in  DATA_WIDTH  push payload.
- push_ready  out  1  push accepted when push_valid & push_ready.
- pop_valid  out  1  pop data available.
- pop_chan  out  CH_WIDTH  channel of the current pop_data.
- pop_data  out  DATA_WIDTH  head entry of the granted channel.
- pop_ready  in  1  pop accepted when pop_valid & pop_ready.
- flush  in  NUM_CHANNELS  per-channel synchronous clear, level-sensitive.
- chan_lvl  out  NUM_CHANNELS*(CNT_WIDTH+1)  per-channel level, flattened; channel i in [i*(CNT_WIDTH+1) +: CNT_WIDTH+1].
- chan_full  out  NUM_CHANNELS  level == FIFO_DEPTH.
- chan_empty  out  NUM_CHANNELS  level == 0.
- chan_afull  out  NUM_CHANNELS  level >= AFULL_LVL.

Behaviour:
- Reset (async assert, sync release):
  - all rd/wr pointers and levels 0; chan_empty all 1; chan_full and chan_afull all 0.
  - pop_valid 0, pop_chan 0, arbiter last-grant = NUM_CHANNELS-1 (first grant goes to channel 0).
  - memory contents are not reset.
- Storage:
  - one array of NUM_CHANNELS*FIFO_DEPTH entries; channel c owns addresses c*FIFO_DEPTH .. c*FIFO_DEPTH+FIFO_DEPTH-1.
  - per-channel pointers are CNT_WIDTH bits and wrap naturally (power-of-two depth).
  - level is an explicit CNT_WIDTH+1 counter per channel; flags are derived from it combinationally.
- Push:
  - push_ready = !chan_full[push_chan] & !flush[push_chan]. It does not depend on push_valid.
  - On accept: write memory, increment wr_ptr and level. Data is poppable the next cycle (1-cycle push-to-pop latency).
  - push_chan >= NUM_CHANNELS: push_ready = 0 and the push is never accepted.
- Pop arbitration (state: grant register plus a locked bit):
  - IDLE (not locked): each cycle, grant the first non-empty channel searching from last-grant+1 with wrap. pop_valid = 1 if any channel is non-empty. pop_chan/pop_data are combinational from the grant.
  - A stall (pop_valid & !pop_ready) moves to LOCKED. The grant, pop_chan and pop_data must stay stable until accepted.
  - On accept: increment rd_ptr and decrement level of the granted channel, set last-grant = pop_chan, and return to IDLE. Throughput is one pop per cycle with fairness across channels.
- Simultaneous push and pop on the same channel: the level is unchanged and both pointers advance. A full channel still refuses the push even if it pops that cycle.
- Flush[c]:
  - next cycle: channel c pointers and level = 0, chan_empty[c] = 1.
  - overrides a push or pop on c in the same cycle: the push is not accepted (push_ready = 0) and the pop is not counted.
  - if c is the granted channel, the lock is released; this is the only case where a stalled pop may be withdrawn.
- Level width: CNT_WIDTH+1 bits, never exceeds FIFO_DEPTH and never underflows; the verification bench asserts this.

Optional Feature:
- Macro CFS_FIFO_MC_STATS_EN.
- With the macro defined:
  - extra output push_drop_cnt, 16 bits, plus an input stats_clr (1 bit).
  - the counter increments on every cycle with push_valid & !push_ready and saturates at 16'hFFFF.
  - stats_clr sets it to 0 synchronously and has priority over the increment.
  - the counter resets to 0.
- Without the macro: neither port exists and no counter logic is present.

Decomposition:
- Package cfs_fifo_mc_pkg holds:
  - the legality-check constants MIN_DEPTH = 2 and MIN_CHANNELS = 2;
  - the STATS_CNT_WIDTH = 16 constant;
  - a function returning the chan_lvl slice offset.
- The arbiter is one natural sub-module: cfs_rr_arbiter. It is parametrised by N, takes a request vector, hold and advance inputs, and outputs a one-hot grant and an index.
- The FIFO control stays in cfs_fifo_mc.

Test Plan:
- Reset, then push 0xA1 on ch2 -> next cycle pop_valid=1, pop_chan=2, pop_data=0xA1; chan_lvl[2]=1.
- Push 8 words to ch0 (FIFO_DEPTH=8) -> chan_full[0]=1, push_ready=0 for ch0 while ch1 pushes are still accepted; chan_afull[0] rises at level 6.
- Fill ch0, ch1 and ch3 with 2 words each, pop_ready=1 -> pop_chan sequence 0,1,3,0,1,3.
- Hold pop_ready=0 for 5 cycles with ch1 granted while pushing ch0 -> pop_chan=1 and pop_data stable throughout; after accept, next grant is ch0.
- Assert flush[1] while ch1 is granted and stalled with level 3 -> next cycle chan_empty[1]=1, chan_lvl[1]=0, grant moves to the next non-empty channel.
- Drop reset_n mid-burst, then under CFS_FIFO_MC_STATS_EN push to a full channel for 4 cycles -> after reset all flags are reset values; push_drop_cnt=4, and stats_clr returns it to 0.
